// File: rtl/cp0_exc_handler_pkg.sv
// Shared CP0 definitions: exception type codes, CP0 register addresses and
// Status/Cause bit positions, plus a small classification helper.
package cp0_exc_handler_pkg;

  typedef enum logic [4:0] {
    EXC_INT         = 5'd0,
    EXC_MOD         = 5'd1,
    EXC_TLBL        = 5'd2,
    EXC_TLBS        = 5'd3,
    EXC_ADEL        = 5'd4,
    EXC_ADES        = 5'd5,
    EXC_IBE         = 5'd6,
    EXC_DBE         = 5'd7,
    EXC_SYS         = 5'd8,
    EXC_BP          = 5'd9,
    EXC_RI          = 5'd10,
    EXC_CPU         = 5'd11,
    EXC_OV          = 5'd12,
    EXC_TR          = 5'd13,
    EXC_ADDR_ERR_IF = 5'd30,
    EXC_ERET        = 5'd31
  } exception_type_e;

  localparam logic [4:0] CP0_ADDR_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_ADDR_COUNT    = 5'd9;
  localparam logic [4:0] CP0_ADDR_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_ADDR_STATUS   = 5'd12;
  localparam logic [4:0] CP0_ADDR_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_ADDR_EPC      = 5'd14;

  localparam int unsigned STATUS_IE_BIT  = 32'd0;
  localparam int unsigned STATUS_EXL_BIT = 32'd1;
  localparam int unsigned STATUS_IM_LO   = 32'd8;
  localparam int unsigned STATUS_IM_HI   = 32'd15;
  localparam int unsigned STATUS_BEV_BIT = 32'd22;

  localparam int unsigned CAUSE_EXC_LO   = 32'd2;
  localparam int unsigned CAUSE_EXC_HI   = 32'd6;
  localparam int unsigned CAUSE_IPSW_LO  = 32'd8;
  localparam int unsigned CAUSE_IPSW_HI  = 32'd9;
  localparam int unsigned CAUSE_IPHW_LO  = 32'd10;
  localparam int unsigned CAUSE_IPHW_HI  = 32'd15;
  localparam int unsigned CAUSE_BD_BIT   = 32'd31;

  // Address-error exceptions are the only ones that capture BadVAddr.
  function automatic logic is_addr_err(input logic [4:0] code);
    logic r;
    r = 1'b0;
    case (code)
      EXC_ADEL, EXC_ADES, EXC_ADDR_ERR_IF: r = 1'b1;
      default:                             r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cp0_exc_handler_if.sv
// Commit-side bus into CP0: exception/ERET event plus mtc0 write and mfc0
// read ports. master = pipeline side, slave = CP0 side.
interface cp0_exc_handler_if;
  logic        exc_valid;
  logic [4:0]  exc_type;
  logic [31:0] exc_pc;
  logic        exc_is_ds;
  logic [31:0] exc_badvaddr;
  logic        mtc0_we;
  logic [4:0]  mtc0_addr;
  logic [31:0] mtc0_wdata;
  logic [4:0]  mfc0_addr;
  logic [31:0] mfc0_rdata;

  modport master (
    output exc_valid, exc_type, exc_pc, exc_is_ds, exc_badvaddr,
    output mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    input  mfc0_rdata
  );

  modport slave (
    input  exc_valid, exc_type, exc_pc, exc_is_ds, exc_badvaddr,
    input  mtc0_we, mtc0_addr, mtc0_wdata, mfc0_addr,
    output mfc0_rdata
  );
endinterface

// File: rtl/cp0_exc_handler_timer.sv
// cp0_timer: Count/Compare timer. Count advances once every two clocks via
// a tick toggle; counter_int latches on Count == Compare and is cleared
// only by a Compare write. Instantiated only when CP0_TIMER_INT_EN is set.
module cp0_timer (
  input  logic        clk,
  input  logic        rst,
  input  logic        count_we_i,
  input  logic        compare_we_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] count_o,
  output logic [31:0] compare_o,
  output logic        counter_int_o
);

  logic [31:0] count_q, count_d;
  logic [31:0] compare_q, compare_d;
  logic        tick_q, tick_d;
  logic        int_q, int_d;

  // Next-state: Count load clears the tick; Compare write beats a match.
  always_comb begin
    count_d   = count_q;
    tick_d    = ~tick_q;
    compare_d = compare_q;
    int_d     = int_q;
    if (count_we_i) begin
      count_d = wdata_i;
      tick_d  = 1'b0;
    end else if (tick_q) begin
      count_d = count_q + 32'd1;
    end else begin
      count_d = count_q;
    end
    if (compare_we_i) begin
      compare_d = wdata_i;
      int_d     = 1'b0;
    end else if (count_q == compare_q) begin
      int_d = 1'b1;
    end else begin
      int_d = int_q;
    end
  end

  // Timer state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 32'd0;
      compare_q <= 32'd0;
      tick_q    <= 1'b0;
      int_q     <= 1'b0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      tick_q    <= tick_d;
      int_q     <= int_d;
    end
  end

  assign count_o       = count_q;
  assign compare_o     = compare_q;
  assign counter_int_o = int_q;

endmodule

// File: rtl/cp0_exc_handler.sv
// cp0_exc_handler: CP0 exception state (Status, Cause, EPC, BadVAddr) with
// mtc0/mfc0 access. An exception/ERET event in the same cycle as an mtc0
// drops the write. Optional Count/Compare timer under macro CP0_TIMER_INT_EN;
// without it Count/Compare read 0 and counter_int is tied low.
module cp0_exc_handler
  import cp0_exc_handler_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         ext_int_i,
  cp0_exc_handler_if.slave   bus,
  output logic [31:0]        epc_o,
  output logic               status_ie_o,
  output logic               status_exl_o,
  output logic [5:0]         status_im_o,
  output logic [1:0]         status_im_sw_o,
  output logic [1:0]         cause_ip_sw_o,
  output logic               counter_int_o
);

  logic [31:0] badvaddr_q, badvaddr_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  status_im_q, status_im_d;
  logic        status_exl_q, status_exl_d;
  logic        status_ie_q, status_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_iphw_q, cause_iphw_d;
  logic [1:0]  cause_ipsw_q, cause_ipsw_d;
  logic [4:0]  cause_exc_q, cause_exc_d;

  logic [31:0] count_s;
  logic [31:0] compare_s;
  logic        counter_int_s;
  logic [31:0] status_rd_s;
  logic [31:0] cause_rd_s;
  logic [31:0] rdata_s;
  logic        unused_ext_int_s;

  // ext_int[5] is shared with the timer interrupt slot and is not sampled.
  assign unused_ext_int_s = ext_int_i[5];

`ifdef CP0_TIMER_INT_EN
  logic count_we_s;
  logic compare_we_s;

  assign count_we_s   = bus.mtc0_we && !bus.exc_valid && (bus.mtc0_addr == CP0_ADDR_COUNT);
  assign compare_we_s = bus.mtc0_we && !bus.exc_valid && (bus.mtc0_addr == CP0_ADDR_COMPARE);

  cp0_timer u_timer (
    .clk           (clk),
    .rst           (rst),
    .count_we_i    (count_we_s),
    .compare_we_i  (compare_we_s),
    .wdata_i       (bus.mtc0_wdata),
    .count_o       (count_s),
    .compare_o     (compare_s),
    .counter_int_o (counter_int_s)
  );
`else
  assign count_s       = 32'd0;
  assign compare_s     = 32'd0;
  assign counter_int_s = 1'b0;
`endif

  // Next-state: exception/ERET has priority over mtc0; hw IP sampled always.
  always_comb begin
    badvaddr_d   = badvaddr_q;
    epc_d        = epc_q;
    status_im_d  = status_im_q;
    status_exl_d = status_exl_q;
    status_ie_d  = status_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_ipsw_d = cause_ipsw_q;
    cause_exc_d  = cause_exc_q;
    cause_iphw_d = {counter_int_s, ext_int_i[4:0]};
    if (bus.exc_valid) begin
      if (bus.exc_type == EXC_ERET) begin
        status_exl_d = 1'b0;
      end else begin
        cause_exc_d  = bus.exc_type;
        status_exl_d = 1'b1;
        if (!status_exl_q) begin
          epc_d      = bus.exc_is_ds ? (bus.exc_pc - 32'd4) : bus.exc_pc;
          cause_bd_d = bus.exc_is_ds;
        end else begin
          epc_d      = epc_q;
          cause_bd_d = cause_bd_q;
        end
        if (is_addr_err(bus.exc_type)) begin
          badvaddr_d = bus.exc_badvaddr;
        end else begin
          badvaddr_d = badvaddr_q;
        end
      end
    end else if (bus.mtc0_we) begin
      case (bus.mtc0_addr)
        CP0_ADDR_BADVADDR: badvaddr_d = bus.mtc0_wdata;
        CP0_ADDR_STATUS: begin
          status_im_d  = bus.mtc0_wdata[STATUS_IM_HI:STATUS_IM_LO];
          status_exl_d = bus.mtc0_wdata[STATUS_EXL_BIT];
          status_ie_d  = bus.mtc0_wdata[STATUS_IE_BIT];
        end
        CP0_ADDR_CAUSE:  cause_ipsw_d = bus.mtc0_wdata[CAUSE_IPSW_HI:CAUSE_IPSW_LO];
        CP0_ADDR_EPC:    epc_d = bus.mtc0_wdata;
        default:         badvaddr_d = badvaddr_q;
      endcase
    end else begin
      badvaddr_d = badvaddr_q;
    end
  end

  // CP0 state register; a reset cycle discards any concurrent update.
  always_ff @(posedge clk) begin
    if (rst) begin
      badvaddr_q   <= 32'd0;
      epc_q        <= 32'd0;
      status_im_q  <= 8'd0;
      status_exl_q <= 1'b0;
      status_ie_q  <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_iphw_q <= 6'd0;
      cause_ipsw_q <= 2'd0;
      cause_exc_q  <= 5'd0;
    end else begin
      badvaddr_q   <= badvaddr_d;
      epc_q        <= epc_d;
      status_im_q  <= status_im_d;
      status_exl_q <= status_exl_d;
      status_ie_q  <= status_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_iphw_q <= cause_iphw_d;
      cause_ipsw_q <= cause_ipsw_d;
      cause_exc_q  <= cause_exc_d;
    end
  end

  // Assemble architectural Status/Cause words; BEV is hardwired to 1.
  always_comb begin
    status_rd_s                              = 32'd0;
    status_rd_s[STATUS_BEV_BIT]              = 1'b1;
    status_rd_s[STATUS_IM_HI:STATUS_IM_LO]   = status_im_q;
    status_rd_s[STATUS_EXL_BIT]              = status_exl_q;
    status_rd_s[STATUS_IE_BIT]               = status_ie_q;
    cause_rd_s                               = 32'd0;
    cause_rd_s[CAUSE_BD_BIT]                 = cause_bd_q;
    cause_rd_s[CAUSE_IPHW_HI:CAUSE_IPHW_LO]  = cause_iphw_q;
    cause_rd_s[CAUSE_IPSW_HI:CAUSE_IPSW_LO]  = cause_ipsw_q;
    cause_rd_s[CAUSE_EXC_HI:CAUSE_EXC_LO]    = cause_exc_q;
  end

  // Combinational mfc0 read mux; unimplemented addresses read zero.
  always_comb begin
    rdata_s = 32'd0;
    case (bus.mfc0_addr)
      CP0_ADDR_BADVADDR: rdata_s = badvaddr_q;
      CP0_ADDR_COUNT:    rdata_s = count_s;
      CP0_ADDR_COMPARE:  rdata_s = compare_s;
      CP0_ADDR_STATUS:   rdata_s = status_rd_s;
      CP0_ADDR_CAUSE:    rdata_s = cause_rd_s;
      CP0_ADDR_EPC:      rdata_s = epc_q;
      default:           rdata_s = 32'd0;
    endcase
  end

  assign bus.mfc0_rdata = rdata_s;
  assign epc_o          = epc_q;
  assign status_ie_o    = status_ie_q;
  assign status_exl_o   = status_exl_q;
  assign status_im_o    = status_im_q[7:2];
  assign status_im_sw_o = status_im_q[1:0];
  assign cause_ip_sw_o  = cause_ipsw_q;
  assign counter_int_o  = counter_int_s;

endmodule

// File: tb/tb_cp0_exc_handler.sv
// Bench for cp0_exc_handler: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a register-level
// model (masks, Count = base + elapsed/2). Honours CP0_TIMER_INT_EN.
module tb_cp0_exc_handler;
  import cp0_exc_handler_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  ext_int;
  logic [31:0] epc;
  logic        status_ie, status_exl, counter_int;
  logic [5:0]  status_im;
  logic [1:0]  status_im_sw, cause_ip_sw;

  cp0_exc_handler_if bus();

  cp0_exc_handler dut (
    .clk            (clk),
    .rst            (rst),
    .ext_int_i      (ext_int),
    .bus            (bus.slave),
    .epc_o          (epc),
    .status_ie_o    (status_ie),
    .status_exl_o   (status_exl),
    .status_im_o    (status_im),
    .status_im_sw_o (status_im_sw),
    .cause_ip_sw_o  (cause_ip_sw),
    .counter_int_o  (counter_int)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  // Model state: full architectural register words.
  logic [31:0] m_status, m_cause, m_epc, m_badv, m_count_base, m_compare;
  int unsigned m_ticks;
  logic        m_cint;
  logic [4:0]  types [0:15];

  function automatic logic [31:0] m_count();
`ifdef CP0_TIMER_INT_EN
    return m_count_base + (m_ticks >> 1);
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] m_cmp();
`ifdef CP0_TIMER_INT_EN
    return m_compare;
`else
    return 32'd0;
`endif
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a)
      5'd8:    return m_badv;
      5'd9:    return m_count();
      5'd11:   return m_cmp();
      5'd12:   return m_status;
      5'd13:   return m_cause;
      5'd14:   return m_epc;
      default: return 32'd0;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic [31:0] cnt_old, cmp_old;
    logic        cint_old, cmp_wr;
    if (rst) begin
      m_status = 32'h0040_0000; m_cause = 32'd0; m_epc = 32'd0; m_badv = 32'd0;
      m_count_base = 32'd0; m_compare = 32'd0; m_ticks = 0; m_cint = 1'b0;
    end else begin
      cnt_old  = m_count();
      cmp_old  = m_cmp();
      cint_old = m_cint;
      cmp_wr   = bus.mtc0_we && !bus.exc_valid && (bus.mtc0_addr == 5'd11);
      m_ticks++;
      if (bus.exc_valid) begin
        if (bus.exc_type == EXC_ERET) begin
          m_status[1] = 1'b0;
        end else begin
          if (!m_status[1]) begin
            m_epc = bus.exc_is_ds ? bus.exc_pc - 32'd4 : bus.exc_pc;
            m_cause[31] = bus.exc_is_ds;
          end
          m_status[1] = 1'b1;
          m_cause[6:2] = bus.exc_type;
          if (bus.exc_type == EXC_ADEL || bus.exc_type == EXC_ADES ||
              bus.exc_type == EXC_ADDR_ERR_IF)
            m_badv = bus.exc_badvaddr;
        end
      end else if (bus.mtc0_we) begin
        case (bus.mtc0_addr)
          5'd8:  m_badv = bus.mtc0_wdata;
          5'd9:  begin m_count_base = bus.mtc0_wdata; m_ticks = 0; end
          5'd11: m_compare = bus.mtc0_wdata;
          5'd12: m_status = (m_status & ~32'h0000_FF03) | (bus.mtc0_wdata & 32'h0000_FF03);
          5'd13: m_cause = (m_cause & ~32'h0000_0300) | (bus.mtc0_wdata & 32'h0000_0300);
          5'd14: m_epc = bus.mtc0_wdata;
          default: ;
        endcase
      end
`ifdef CP0_TIMER_INT_EN
      if (cmp_wr) m_cint = 1'b0;
      else if (cnt_old == cmp_old) m_cint = 1'b1;
`else
      m_cint = 1'b0;
`endif
      m_cause[15:10] = {cint_old, ext_int[4:0]};
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.exc_valid = 1'b0;
    bus.mtc0_we   = 1'b0;
  endtask

  task automatic exc(input logic [4:0] t, input logic [31:0] pc, input logic ds, input logic [31:0] bv);
    bus.exc_valid = 1'b1; bus.exc_type = t; bus.exc_pc = pc;
    bus.exc_is_ds = ds; bus.exc_badvaddr = bv;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    bus.mtc0_we = 1'b1; bus.mtc0_addr = a; bus.mtc0_wdata = d;
  endtask

  task automatic rd_chk(input string name, input logic [4:0] a, input logic [31:0] exp);
    bus.mfc0_addr = a;
    #1;
    check(name, bus.mfc0_rdata, exp);
  endtask

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("mfc0_rdata", bus.mfc0_rdata, model_read(bus.mfc0_addr));
      check("epc", epc, m_epc);
      check("status_ie", {31'd0, status_ie}, {31'd0, m_status[0]});
      check("status_exl", {31'd0, status_exl}, {31'd0, m_status[1]});
      check("status_im", {26'd0, status_im}, {26'd0, m_status[15:10]});
      check("status_im_sw", {30'd0, status_im_sw}, {30'd0, m_status[9:8]});
      check("cause_ip_sw", {30'd0, cause_ip_sw}, {30'd0, m_cause[9:8]});
      check("counter_int", {31'd0, counter_int}, {31'd0, m_cint});
    end
  end

  initial begin
    int n;
    logic [4:0] a;
    types[0] = EXC_INT;  types[1] = EXC_MOD;  types[2] = EXC_TLBL; types[3] = EXC_TLBS;
    types[4] = EXC_ADEL; types[5] = EXC_ADES; types[6] = EXC_IBE;  types[7] = EXC_DBE;
    types[8] = EXC_SYS;  types[9] = EXC_BP;   types[10] = EXC_RI;  types[11] = EXC_CPU;
    types[12] = EXC_OV;  types[13] = EXC_TR;  types[14] = EXC_ADDR_ERR_IF; types[15] = EXC_ERET;

    rst = 1'b1; ext_int = 6'd0; idle();
    bus.exc_type = 5'd0; bus.exc_pc = 32'd0; bus.exc_is_ds = 1'b0; bus.exc_badvaddr = 32'd0;
    bus.mtc0_addr = 5'd0; bus.mtc0_wdata = 32'd0; bus.mfc0_addr = 5'd12;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;

    // Reset values.
    rd_chk("reset Count", 5'd9, 32'd0);
    rd_chk("reset Status", 5'd12, 32'h0040_0000);
    rd_chk("reset Cause", 5'd13, 32'd0);
    rd_chk("reset EPC", 5'd14, 32'd0);

    // Ov in delay slot, then ERET.
    exc(EXC_OV, 32'h8000_1004, 1'b1, 32'd0); step(); idle();
    check("ov EPC", epc, 32'h8000_1000);
    bus.mfc0_addr = 5'd13; #1;
    check("ov BD", {31'd0, bus.mfc0_rdata[31]}, 32'd1);
    check("ov ExcCode", {27'd0, bus.mfc0_rdata[6:2]}, 32'd12);
    check("ov EXL", {31'd0, status_exl}, 32'd1);
    exc(EXC_ERET, 32'h1234_5678, 1'b1, 32'd0); step(); idle();
    check("eret EXL", {31'd0, status_exl}, 32'd0);
    check("eret EPC", epc, 32'h8000_1000);

    // Nested exception keeps EPC.
    exc(EXC_SYS, 32'h8000_0100, 1'b0, 32'd0); step(); idle();
    check("sys EPC", epc, 32'h8000_0100);
    exc(EXC_RI, 32'h8000_2000, 1'b0, 32'd0); step(); idle();
    check("nested EPC", epc, 32'h8000_0100);
    bus.mfc0_addr = 5'd13; #1;
    check("nested ExcCode", {27'd0, bus.mfc0_rdata[6:2]}, 32'd10);

    // BadVAddr capture only on address errors.
    exc(EXC_ADEL, 32'h8000_0200, 1'b0, 32'h0000_0003); step(); idle();
    rd_chk("adel BadVAddr", 5'd8, 32'h0000_0003);
    exc(EXC_SYS, 32'h8000_0300, 1'b0, 32'hDEAD_BEEF); step(); idle();
    rd_chk("sys BadVAddr", 5'd8, 32'h0000_0003);

    // Exception beats a simultaneous mtc0.
    mtc0(5'd12, 32'd0); step(); idle();
    rd_chk("status cleared", 5'd12, 32'h0040_0000);
    mtc0(5'd12, 32'h0000_FF01); exc(EXC_BP, 32'h8000_0400, 1'b0, 32'd0); step(); idle();
    rd_chk("bp+mtc0 Status", 5'd12, 32'h0040_0002);
    bus.mfc0_addr = 5'd13; #1;
    check("bp ExcCode", {27'd0, bus.mfc0_rdata[6:2]}, 32'd9);

`ifdef CP0_TIMER_INT_EN
    // Count=0 then Compare=10 (that write collides with a 0==0 match).
    mtc0(5'd9, 32'd0); step();
    mtc0(5'd11, 32'd10); step(); idle();
    check("match+clear cint", {31'd0, counter_int}, 32'd0);
    n = 0;
    while (!counter_int && n < 40) begin step(); n++; end
    check("timer latency", n, 32'd20);
    step(); step();
    check("cint hold", {31'd0, counter_int}, 32'd1);
    mtc0(5'd11, 32'hFFFF_0000); step(); idle();
    check("cint cleared", {31'd0, counter_int}, 32'd0);
`else
    mtc0(5'd11, 32'd10); step();
    mtc0(5'd9, 32'd0); step(); idle();
    n = 0;
    for (int i = 0; i < 25; i++) begin step(); if (counter_int) n++; end
    check("cint tied low", n, 32'd0);
    rd_chk("count absent", 5'd9, 32'd0);
    rd_chk("compare absent", 5'd11, 32'd0);
`endif

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      ext_int = 6'($urandom);
      bus.exc_valid = ($urandom_range(0, 9) == 0);
      bus.exc_type = types[$urandom_range(0, 15)];
      bus.exc_pc = $urandom;
      bus.exc_is_ds = 1'($urandom);
      bus.exc_badvaddr = $urandom;
      bus.mtc0_we = ($urandom_range(0, 3) == 0);
      case ($urandom_range(0, 7))
        0: a = 5'd8;  1: a = 5'd9;  2, 3: a = 5'd11; 4: a = 5'd12;
        5: a = 5'd13; 6: a = 5'd14; default: a = 5'($urandom);
      endcase
      bus.mtc0_addr = a;
      bus.mtc0_wdata = $urandom;
      if (a == 5'd11 && $urandom_range(0, 1) == 1)
        bus.mtc0_wdata = m_count() + 32'($urandom_range(0, 3));
      if (a == 5'd9 && $urandom_range(0, 3) == 0)
        bus.mtc0_wdata = 32'hFFFF_FFFC;
      bus.mfc0_addr = 5'($urandom_range(0, 15));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
